pipelined_config_tree_adder: RTL and testbench
==============================================

// Module: pipelined_config_tree_adder
// PURPOSE
// - Pipelined successor of the combinational configurable tree adder: reduces INPUTS_AMOUNT signed P-bit words to one signed sum.
// - Three precision modes: each P-bit input word carries 1, 2 or 4 packed signed lanes, and every lane is summed.
// - One register per tree level, valid/ready handshake on both sides. Sits between the PE multiplier array and the output/requant stage.
// PARAMETERS
// - P              16  input word width; must be divisible by 4
// - INPUTS_AMOUNT  8   number of input words; power of two, >= 2
// - OUT_W          32  output width; must be >= P + $clog2(4*INPUTS_AMOUNT)
// PORTS
// - clk        in   1                  single clock, rising edge
// - rst        in   1                  synchronous reset, active-high
// - in_valid   in   1                  input beat valid
// - in_ready   out  1                  block can accept a beat
// - mode       in   2                  00 full (1x P), 01 halved (2x P/2), 10 quarter (4x P/4), 11 reserved (treated as 00); sampled with the beat
// - inputs     in   P x INPUTS_AMOUNT  signed words (unpacked array); lane 0 = MSBs
// - in_first   in   1                  accumulator restart (port present only with CFG_TREE_ACCUM_EN)
// - out_valid  out  1                  result valid
// - out_ready  in   1                  downstream accepts the result
// - out        out  OUT_W              signed sum
// BEHAVIOUR
// - LEVELS = $clog2(INPUTS_AMOUNT). Stage 0 unpacks lanes and adds pairs of words; each later stage adds pairs of partial sums.
//   Every stage is registered, so latency is exactly LEVELS cycles from input handshake to out_valid.
// - Lane unpack: each lane is sign-extended to OUT_W before any addition.
//   - Per word: mode 00 contributes its full P-bit value.
//   - Mode 01: sum of its two P/2 lanes. Mode 10: sum of its four P/4 lanes.
// - All arithmetic is two's complement in OUT_W bits; no saturation. Overflow cannot occur under the OUT_W rule.
// - Mode travels with the data: consecutive beats may use different modes with no bubble.
// - Handshake
//   - Input accepted when in_valid && in_ready. Output transferred when out_valid && out_ready.
//   - in_ready = out_ready || !out_valid. When !in_ready the whole pipeline holds (global stall) and out stays stable.
//   - Bubbles: a stage with valid=0 advances freely. in_valid=0 inserts a bubble; data of bubble stages is don't-care.
//   - out and out_valid must not change while out_valid && !out_ready.
//   - Full throughput: 1 beat/cycle when out_ready is held high.
// - Reset (rst=1 at posedge): all stage valid bits are cleared, out=0, out_valid=0, accumulator=0.
//   - in_ready = 1 in the cycle after reset; during reset in_ready is don't-care.
//   - Reset mid-operation discards all in-flight beats; no partial result appears afterwards.
// - Simultaneous accept and emit in the same cycle is legal and required for full throughput.
// CONFIGURATION
// - CFG_TREE_ACCUM_EN defined: adds port in_first and an OUT_W-bit accumulator in the last stage.
//   - in_first travels with its beat.
//   - On emit: acc <= in_first ? sum : acc + sum, and out = the new acc (running total). Wraps modulo 2^OUT_W.
//   - Latency is unchanged. acc updates only when the last stage advances with valid=1 (not on stalls or bubbles).
// - CFG_TREE_ACCUM_EN undefined: no in_first port, no accumulator; out = per-beat sum.
// TESTING
// - Mode 00, inputs {1,2,3,4,5,6,7,8}, out_ready=1 -> out=36 exactly 3 cycles after accept. Inputs {-127,5,2,1,-6,1,-35,6} -> -153.
// - Mode 01, words packing lanes 1..16 -> 136; lanes -1..-16 -> -136; lanes {127,-128} in word 0, rest 0 -> -1.
// - Mode 10, every nibble 0xF (value -1) -> -32. Word 0 = 16'h7777, rest 0 -> 28.
// - Back-to-back beats in modes 00/01/10/00 with out_ready=1 -> 4 correct results on 4 consecutive cycles.
//   Then hold out_ready=0 for 5 cycles -> out stable, in_ready=0, no beat lost or duplicated.
// - Assert rst with 2 beats in flight -> out_valid=0 the next cycle and no stale result is ever emitted. Plus 200 random beats (random modes, valid, ready) checked against a scoreboard.
// - CFG_TREE_ACCUM_EN: beats 36 (in_first=1), -4, 183 -> outs 36, 32, 215. Next in_first=1 beat with sum 0 -> out 0.

Source files
------------

// File: rtl/pipelined_config_tree_adder.sv
// Pipelined configurable-precision adder tree: one register per tree level, valid/ready on both sides.
// Optional running-total accumulator in the last stage when CFG_TREE_ACCUM_EN is defined.
module pipelined_config_tree_adder #(
    parameter int unsigned P             = 16,
    parameter int unsigned INPUTS_AMOUNT = 8,
    parameter int unsigned OUT_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic [P-1:0]            inputs [INPUTS_AMOUNT],
`ifdef CFG_TREE_ACCUM_EN
    input  logic                    in_first,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out
);

    localparam int unsigned LEVELS  = $clog2(INPUTS_AMOUNT);
    localparam int unsigned NODES   = INPUTS_AMOUNT - 1;
    localparam int unsigned ROOT    = NODES - 1;
    localparam int unsigned HALF    = P / 2;
    localparam int unsigned QUARTER = P / 4;

    // Node storage is a flat heap: level l occupies INPUTS_AMOUNT>>(l+1) slots starting here.
    function automatic int unsigned level_base(input int unsigned l);
        return INPUTS_AMOUNT - (INPUTS_AMOUNT >> l);
    endfunction

    // Sign-extend every packed lane of one word and sum the lanes.
    function automatic logic signed [OUT_W-1:0] unpack_word(input logic [P-1:0] w,
                                                            input logic [1:0]   m);
        logic signed [OUT_W-1:0] s;
        s = '0;
        case (m)
            2'b01: begin
                for (int unsigned j = 0; j < 2; j++)
                    s = s + OUT_W'($signed(w[j*HALF +: HALF]));
            end
            2'b10: begin
                for (int unsigned j = 0; j < 4; j++)
                    s = s + OUT_W'($signed(w[j*QUARTER +: QUARTER]));
            end
            default: s = OUT_W'($signed(w));
        endcase
        return s;
    endfunction

    logic signed [OUT_W-1:0] word_val [INPUTS_AMOUNT];
    logic signed [OUT_W-1:0] node_c   [NODES];
    logic signed [OUT_W-1:0] node_q   [NODES];
    logic [LEVELS-1:0]       valid_q;
    logic [LEVELS-1:0]       stage_vin;
    logic                    advance;

    assign in_ready  = out_ready || !out_valid;
    assign advance   = in_ready;
    assign out_valid = valid_q[LEVELS-1];
    assign out       = node_q[ROOT];

    always_comb begin
        for (int unsigned k = 0; k < INPUTS_AMOUNT; k++)
            word_val[k] = unpack_word(inputs[k], mode);
    end

    // Adders feeding every tree register; level 0 reads the unpacked words.
    always_comb begin
        for (int unsigned k = 0; k < NODES; k++)
            node_c[k] = '0;
        for (int unsigned i = 0; i < INPUTS_AMOUNT / 2; i++)
            node_c[i] = word_val[2*i] + word_val[2*i+1];
        for (int unsigned l = 1; l < LEVELS; l++) begin
            for (int unsigned i = 0; i < (INPUTS_AMOUNT >> (l + 1)); i++)
                node_c[level_base(l) + i] = node_q[level_base(l - 1) + 2*i]
                                          + node_q[level_base(l - 1) + 2*i + 1];
        end
    end

    always_comb begin
        stage_vin    = '0;
        stage_vin[0] = in_valid;
        for (int unsigned l = 1; l < LEVELS; l++)
            stage_vin[l] = valid_q[l-1];
    end

`ifdef CFG_TREE_ACCUM_EN
    logic [LEVELS-1:0] first_q;
    logic [LEVELS-1:0] stage_first;

    always_comb begin
        stage_first    = '0;
        stage_first[0] = in_first;
        for (int unsigned l = 1; l < LEVELS; l++)
            stage_first[l] = first_q[l-1];
    end
`endif

    // Global stall: every level moves together whenever the output side can take a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < NODES; k++)
                node_q[k] <= '0;
`ifdef CFG_TREE_ACCUM_EN
            first_q <= '0;
`endif
        end else if (advance) begin
            valid_q <= stage_vin;
            for (int unsigned k = 0; k < ROOT; k++)
                node_q[k] <= node_c[k];
`ifdef CFG_TREE_ACCUM_EN
            first_q <= stage_first;
            // Root doubles as the accumulator; bubbles leave the running total untouched.
            if (stage_vin[LEVELS-1])
                node_q[ROOT] <= stage_first[LEVELS-1] ? node_c[ROOT]
                                                      : node_q[ROOT] + node_c[ROOT];
`else
            node_q[ROOT] <= node_c[ROOT];
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_config_tree_adder.sv
// Directed and scoreboarded bench for pipelined_config_tree_adder (P=16, 8 inputs, OUT_W=32).
module tb_pipelined_config_tree_adder;

    typedef logic [15:0] vec_t [8];

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [15:0]        inputs [8];
    logic               in_first;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out;

    int vectors     = 0;
    int miscompares = 0;

    vec_t v_inc, v_neg, v_l16, v_ln16, v_lim, v_f, v_7, v_min, v_x80, v_zero, v_m4, v_183;
    vec_t       b_vec [4];
    logic [1:0] b_mode [4];
    int         b_exp [4];

    pipelined_config_tree_adder #(.P(16), .INPUTS_AMOUNT(8), .OUT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .inputs   (inputs),
`ifdef CFG_TREE_ACCUM_EN
        .in_first (in_first),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: integer lane extraction with explicit sign correction.
    function automatic int ref_sum(input vec_t w, input logic [1:0] m);
        int s, lw, lane;
        s  = 0;
        lw = (m == 2'b01) ? 8 : (m == 2'b10) ? 4 : 16;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 16 / lw; j++) begin
                lane = (int'(w[k]) >> (lw * j)) & ((1 << lw) - 1);
                if (lane >= (1 << (lw - 1))) lane = lane - (1 << lw);
                s = s + lane;
            end
        end
        return s;
    endfunction

    task automatic init_vectors();
        int nv [8] = '{-127, 5, 2, 1, -6, 1, -35, 6};
        for (int k = 0; k < 8; k++) begin
            v_inc[k]  = 16'(k + 1);
            v_neg[k]  = 16'(nv[k]);
            v_l16[k]  = {8'(2*k + 1), 8'(2*k + 2)};
            v_ln16[k] = {8'(-(2*k + 1)), 8'(-(2*k + 2))};
            v_lim[k]  = 16'h0000;
            v_f[k]    = 16'hFFFF;
            v_7[k]    = 16'h0000;
            v_min[k]  = 16'h8000;
            v_x80[k]  = 16'h8080;
            v_zero[k] = 16'h0000;
            v_m4[k]   = 16'h0000;
            v_183[k]  = 16'h0000;
        end
        v_lim[0] = 16'h7F80;
        v_7[0]   = 16'h7777;
        v_m4[0]  = 16'hFFFC;
        v_183[0] = 16'd183;
        b_vec[0] = v_inc;  b_mode[0] = 2'b00; b_exp[0] = 36;
        b_vec[1] = v_l16;  b_mode[1] = 2'b01; b_exp[1] = 136;
        b_vec[2] = v_f;    b_mode[2] = 2'b10; b_exp[2] = -32;
        b_vec[3] = v_neg;  b_mode[3] = 2'b00; b_exp[3] = -153;
    endtask

    task automatic run_single(input vec_t w, input logic [1:0] m, input logic f,
                              output int res, output int lat);
        @(negedge clk);
        inputs = w; mode = m; in_first = f; in_valid = 1'b1; out_ready = 1'b1;
        res = 0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                res = int'(out);
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out !== 32'sd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b out=%0d in_ready=%b, expected 0 0 1",
                     out_valid, out, in_ready);
        end
    endtask

    task automatic test_mode_full();
        int res, lat;
        run_single(v_inc, 2'b00, 1'b1, res, lat);
        vectors++;
        if (res != 36 || lat != 3) begin
            miscompares++;
            $display("FAIL full_inc: out=%0d lat=%0d, expected 36 lat 3", res, lat);
        end
        run_single(v_neg, 2'b00, 1'b1, res, lat);
        vectors++;
        if (res != -153 || lat != 3) begin
            miscompares++;
            $display("FAIL full_neg: out=%0d lat=%0d, expected -153 lat 3", res, lat);
        end
        run_single(v_min, 2'b00, 1'b1, res, lat);
        vectors++;
        if (res != -262144) begin
            miscompares++;
            $display("FAIL full_min: out=%0d, expected -262144", res);
        end
        run_single(v_inc, 2'b11, 1'b1, res, lat);
        vectors++;
        if (res != 36) begin
            miscompares++;
            $display("FAIL mode11_as_full: out=%0d, expected 36", res);
        end
    endtask

    task automatic test_mode_half();
        int res, lat;
        run_single(v_l16, 2'b01, 1'b1, res, lat);
        vectors++;
        if (res != 136 || lat != 3) begin
            miscompares++;
            $display("FAIL half_pos: out=%0d lat=%0d, expected 136 lat 3", res, lat);
        end
        run_single(v_ln16, 2'b01, 1'b1, res, lat);
        vectors++;
        if (res != -136) begin
            miscompares++;
            $display("FAIL half_neg: out=%0d, expected -136", res);
        end
        run_single(v_lim, 2'b01, 1'b1, res, lat);
        vectors++;
        if (res != -1) begin
            miscompares++;
            $display("FAIL half_limits: out=%0d, expected -1", res);
        end
        run_single(v_x80, 2'b01, 1'b1, res, lat);
        vectors++;
        if (res != -2048) begin
            miscompares++;
            $display("FAIL half_min: out=%0d, expected -2048", res);
        end
    endtask

    task automatic test_mode_quarter();
        int res, lat;
        run_single(v_f, 2'b10, 1'b1, res, lat);
        vectors++;
        if (res != -32 || lat != 3) begin
            miscompares++;
            $display("FAIL quarter_ones: out=%0d lat=%0d, expected -32 lat 3", res, lat);
        end
        run_single(v_7, 2'b10, 1'b1, res, lat);
        vectors++;
        if (res != 28) begin
            miscompares++;
            $display("FAIL quarter_7777: out=%0d, expected 28", res);
        end
    endtask

    task automatic test_back_to_back();
        int gv[$];
        int gc[$];
        int nxt = 0;
        for (int cyc = 0; cyc < 20 && gv.size() < 4; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (nxt < 4) begin
                inputs = b_vec[nxt]; mode = b_mode[nxt]; in_first = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                gv.push_back(int'(out));
                gc.push_back(cyc);
            end
            if (in_valid && in_ready) nxt++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= gv.size()) begin
                miscompares++;
                $display("FAIL b2b_%0d: no result, expected %0d at cycle %0d", k, b_exp[k], 3 + k);
            end else if (gv[k] != b_exp[k] || gc[k] != 3 + k) begin
                miscompares++;
                $display("FAIL b2b_%0d: out=%0d at cycle %0d, expected %0d at cycle %0d",
                         k, gv[k], gc[k], b_exp[k], 3 + k);
            end
        end
    endtask

    task automatic test_stall();
        int gv[$];
        int nxt = 0;
        for (int cyc = 0; cyc < 40 && gv.size() < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 8);
            if (nxt < 4) begin
                inputs = b_vec[nxt]; mode = b_mode[nxt]; in_first = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc < 8) begin
                vectors++;
                if (out_valid !== 1'b1 || out !== 32'sd36 || in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold c%0d: out_valid=%b out=%0d in_ready=%b, expected 1 36 0",
                             cyc, out_valid, out, in_ready);
                end
            end
            if (out_valid && out_ready) gv.push_back(int'(out));
            if (in_valid && in_ready) nxt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= gv.size() || gv[k] != b_exp[k]) begin
                miscompares++;
                $display("FAIL stall_order_%0d: got %0d results, expected %0d", k,
                         (k < gv.size()) ? gv[k] : 0, b_exp[k]);
            end
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_no_dup: out_valid=%b out=%0d, expected out_valid 0", out_valid, out);
        end
    endtask

    task automatic test_reset_midflight();
        int res, lat;
        int stale = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            inputs = b_vec[k]; mode = b_mode[k]; in_first = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_clear: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        vectors++;
        if (stale != 0) begin
            miscompares++;
            $display("FAIL midreset_stale: %0d stale results, expected 0", stale);
        end
        run_single(v_l16, 2'b01, 1'b1, res, lat);
        vectors++;
        if (res != 136 || lat != 3) begin
            miscompares++;
            $display("FAIL midreset_recover: out=%0d lat=%0d, expected 136 lat 3", res, lat);
        end
    endtask

`ifdef CFG_TREE_ACCUM_EN
    task automatic test_accum();
        int res, lat;
        run_single(v_inc, 2'b00, 1'b1, res, lat);
        vectors++;
        if (res != 36 || lat != 3) begin
            miscompares++;
            $display("FAIL acc_first: out=%0d lat=%0d, expected 36 lat 3", res, lat);
        end
        run_single(v_m4, 2'b00, 1'b0, res, lat);
        vectors++;
        if (res != 32) begin
            miscompares++;
            $display("FAIL acc_add_m4: out=%0d, expected 32", res);
        end
        run_single(v_183, 2'b00, 1'b0, res, lat);
        vectors++;
        if (res != 215) begin
            miscompares++;
            $display("FAIL acc_add_183: out=%0d, expected 215", res);
        end
        run_single(v_zero, 2'b00, 1'b1, res, lat);
        vectors++;
        if (res != 0) begin
            miscompares++;
            $display("FAIL acc_restart: out=%0d, expected 0", res);
        end
    endtask
`endif

    task automatic test_random();
        int   sq[$];
        logic fq[$];
        int   got = 0;
        int   sent = 0;
        int   acc_m = 0;
        int   exp_v;
        int   s;
        logic hold = 1'b0;
        logic signed [31:0] hold_out = '0;
        vec_t w;
        do_reset();
        for (int cyc = 0; cyc < 4000 && got < 200; cyc++) begin
            @(negedge clk);
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out !== hold_out) begin
                    miscompares++;
                    $display("FAIL rand_hold c%0d: out_valid=%b out=%0d, expected 1 %0d",
                             cyc, out_valid, out, hold_out);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 200 && $urandom_range(0, 4) != 0) begin
                for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
                inputs   = w;
                mode     = 2'($urandom_range(0, 3));
                in_first = ($urandom_range(0, 3) == 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: out=%0d with nothing outstanding", out);
                end else begin
                    s = sq.pop_front();
`ifdef CFG_TREE_ACCUM_EN
                    acc_m = fq.pop_front() ? s : acc_m + s;
                    exp_v = acc_m;
`else
                    void'(fq.pop_front());
                    exp_v = s;
`endif
                    if (out !== 32'(exp_v)) begin
                        miscompares++;
                        $display("FAIL rand_value #%0d: out=%0d, expected %0d", got, out, exp_v);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sq.push_back(ref_sum(inputs, mode));
                fq.push_back(in_first);
                sent++;
            end
            hold     = out_valid && !out_ready;
            hold_out = out;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (got != 200 || acc_m == 32'h7FFF_FFFF) begin
            miscompares++;
            $display("FAIL rand_count: %0d results, expected 200", got);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; in_first = 1'b0;
        init_vectors();
        inputs = v_zero;
        test_reset();
        test_mode_full();
        test_mode_half();
        test_mode_quarter();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef CFG_TREE_ACCUM_EN
        test_accum();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
